// File: rtl/dtc_vote_accum_if.sv
// Valid/ready stream carrying one class code per transfer.
// Used for both the input side (slave) and the output side (master) of dtc_vote_accum.
interface dtc_vote_accum_if #(
  parameter int WIDTH = 7
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/dtc_vote_accum.sv
// Per-bit majority vote over windows of WIN class codes, one voted code per window.
// Optional macro DTC_VOTE_FLUSH_EN adds a flush input that closes a partial window early.
module dtc_vote_accum #(
  parameter  int WIDTH = 7,
  parameter  int WIN   = 8,
  localparam int CW    = $clog2(WIN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  dtc_vote_accum_if.slave  in_bus,
  dtc_vote_accum_if.master out_bus,
`ifdef DTC_VOTE_FLUSH_EN
  input  logic             flush,
`endif
  output logic [CW-1:0]    win_count
);

  typedef enum logic [0:0] {ACCUM, EMIT} state_t;

  state_t           state, state_nxt;
  logic             in_ready, out_valid;
  logic             in_xfer, out_xfer, close;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] vote;
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    ones     [WIDTH];
  logic [CW-1:0]    ones_nxt [WIDTH];

  assign in_bus.ready  = in_ready;
  assign out_bus.valid = out_valid;
  assign out_bus.data  = out_data;

  assign in_xfer  = in_bus.valid & in_ready;
  assign out_xfer = out_valid & out_bus.ready;

  // Counts after a possible transfer this cycle; the vote compares 2*ones against
  // the window length at CW+1 bits, so exact halves resolve to 0.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    cnt_nxt = win_count + CW'(in_xfer);
    vote    = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones_nxt[b] = ones[b] + CW'(in_xfer & in_bus.data[b]);
      vote[b]     = {ones_nxt[b], 1'b0} > {1'b0, cnt_nxt};
    end
  end

`ifdef DTC_VOTE_FLUSH_EN
  assign close = in_ready & ((in_xfer & (cnt_nxt == CW'(WIN))) | (flush & (cnt_nxt != '0)));
`else
  assign close = in_xfer & (cnt_nxt == CW'(WIN));
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state and counters use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (close)         state_nxt = EMIT;
      EMIT:  if (out_bus.ready) state_nxt = ACCUM;
      default:                  state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == EMIT);
  end

  // Counters clear only after the voted code leaves; in_xfer cannot occur in EMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the per-bit counter array is reset explicitly; a discarded partial
      // window must not leak into the next vote.
      for (int b = 0; b < WIDTH; b++) ones[b] <= '0;
      win_count <= '0;
      out_data  <= '0;
    end else begin
      if (out_xfer) begin
        for (int b = 0; b < WIDTH; b++) ones[b] <= '0;
        win_count <= '0;
      end else if (in_xfer) begin
        for (int b = 0; b < WIDTH; b++) ones[b] <= ones_nxt[b];
        win_count <= cnt_nxt;
      end
      if (close) out_data <= vote;
    end
  end

endmodule

// File: tb/tb_dtc_vote_accum.sv
// Scoreboard bench for dtc_vote_accum (WIDTH=7, WIN=8); flush test when DTC_VOTE_FLUSH_EN is defined.
module tb_dtc_vote_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] win_count;
`ifdef DTC_VOTE_FLUSH_EN
  logic       flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q [$];

  dtc_vote_accum_if #(.WIDTH(7)) in_if ();
  dtc_vote_accum_if #(.WIDTH(7)) out_if ();

  dtc_vote_accum #(.WIDTH(7), .WIN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bus    (in_if),
    .out_bus   (out_if),
`ifdef DTC_VOTE_FLUSH_EN
    .flush     (flush),
`endif
    .win_count (win_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Holds the code until the DUT accepts it; returns 1 time unit after the accepting edge.
  task automatic send(input logic [6:0] d);
    logic r = 1'b0;
    int   n = 0;
    in_if.valid = 1'b1;
    in_if.data  = d;
    while (!r && n < 50) begin
      @(negedge clk);
      r = in_if.ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!r) check("send_timeout", 32'(r), 32'd1);
    in_if.valid = 1'b0;
    in_if.data  = 'x;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_if.valid), 32'd0);
    check({tag, "_out_data"},  32'(out_if.data),  32'd0);
    check({tag, "_win_count"}, 32'(win_count),    32'd0);
    check({tag, "_in_ready"},  32'(in_if.ready),  32'd1);
  endtask

  // Monitor: every output transfer pops one expected code.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_if.valid && out_if.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_spurious got %0h expected no output at %0t", out_if.data, $time);
        end else begin
          check("out_data", 32'(out_if.data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [6:0] bp_codes  [8]  = '{7'b0101010, 7'b0101010, 7'b0101010, 7'b0101011,
                                 7'b1100011, 7'b1000001, 7'b0001110, 7'b0111000};
  logic [6:0] gap_codes [24] = '{7'h13, 7'h7E, 7'h25, 7'h40, 7'h19, 7'h33, 7'h6C, 7'h01,
                                 7'h7F, 7'h7F, 7'h00, 7'h55, 7'h2A, 7'h7F, 7'h0F, 7'h70,
                                 7'h08, 7'h18, 7'h38, 7'h08, 7'h48, 7'h09, 7'h0A, 7'h00};

  initial begin
    in_if.valid  = 1'b0;
    in_if.data   = 'x;
    out_if.ready = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    check_reset_outputs("init");

    // Full window of identical codes; vote visible the cycle after the 8th transfer.
    exp_q.push_back(7'b1000001);
    for (int i = 0; i < 8; i++) send(7'b1000001);
    check("lat_out_valid", 32'(out_if.valid), 32'd1);
    check("lat_in_ready",  32'(in_if.ready),  32'd0);
    check("lat_win_count", 32'(win_count),    32'd8);
    cycles(1);
    check("post_out_valid", 32'(out_if.valid), 32'd0);
    check("post_win_count", 32'(win_count),    32'd0);
    check("post_in_ready",  32'(in_if.ready),  32'd1);
    check("post_retain",    32'(out_if.data),  32'h41);

    // Reset mid-window with in_valid high.
    for (int i = 0; i < 3; i++) send(7'h7F);
    in_if.valid = 1'b1;
    in_if.data  = 7'h7F;
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    in_if.valid = 1'b0;
    cycles(1);
    rst = 1'b0;
    cycles(1);

    // Reset while holding a voted code in EMIT: the code is discarded.
    out_if.ready = 1'b0;
    for (int i = 0; i < 8; i++) send(7'h7F);
    check("emit_out_valid", 32'(out_if.valid), 32'd1);
    check("emit_out_data",  32'(out_if.data),  32'h7F);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_emit");
    cycles(1);
    rst = 1'b0;
    out_if.ready = 1'b1;
    cycles(1);

    // Tie resolves to 0, then a 5/3 split resolves to 1.
    exp_q.push_back(7'b0000000);
    for (int i = 0; i < 4; i++) send(7'b0000001);
    for (int i = 0; i < 4; i++) send(7'b0000000);
    exp_q.push_back(7'b0000001);
    for (int i = 0; i < 5; i++) send(7'b0000001);
    for (int i = 0; i < 3; i++) send(7'b0000000);
    cycles(1);

    // Backpressure: hold EMIT for 5 cycles while offering junk input.
    out_if.ready = 1'b0;
    exp_q.push_back(7'b0101010);
    for (int i = 0; i < 8; i++) send(bp_codes[i]);
    for (int i = 0; i < 5; i++) begin
      in_if.valid = 1'b1;
      in_if.data  = 7'h7F;
      @(negedge clk);
      check("bp_out_valid", 32'(out_if.valid), 32'd1);
      check("bp_out_data",  32'(out_if.data),  32'b0101010);
      check("bp_in_ready",  32'(in_if.ready),  32'd0);
      check("bp_win_count", 32'(win_count),    32'd8);
      @(posedge clk);
      #1;
    end
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    cycles(1);
    check("bp_release_win_count", 32'(win_count),   32'd0);
    check("bp_release_in_ready",  32'(in_if.ready), 32'd1);

    // Three windows with random idle gaps; expected votes from a per-bit tally.
    for (int w = 0; w < 3; w++) begin
      int         ones [7];
      logic [6:0] v;
      for (int b = 0; b < 7; b++) ones[b] = 0;
      for (int i = 0; i < 8; i++)
        for (int b = 0; b < 7; b++) ones[b] += int'(gap_codes[w*8+i][b]);
      for (int b = 0; b < 7; b++) v[b] = (2 * ones[b] > 8);
      exp_q.push_back(v);
      for (int i = 0; i < 8; i++) begin
        send(gap_codes[w*8+i]);
        cycles($urandom_range(0, 4));
      end
    end
    cycles(2);

`ifdef DTC_VOTE_FLUSH_EN
    // Flush on an empty window is ignored; flush after 3 samples votes over 3.
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    check("flush_empty_out_valid", 32'(out_if.valid), 32'd0);
    exp_q.push_back(7'b0110001);
    send(7'b0110001);
    send(7'b0110001);
    send(7'b0000000);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    check("flush_out_valid", 32'(out_if.valid), 32'd1);
    check("flush_win_count", 32'(win_count),    32'd3);
    cycles(1);
    check("flush_cleared",   32'(win_count),    32'd0);
`endif

    for (int n = 0; n < 100 && exp_q.size() != 0; n++) cycles(1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
